// File: rtl/halflife_pkg.sv
// Shared types and defaults for the half-life decay controller.
package halflife_pkg;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned PW_DEF = 8;
    localparam int unsigned HW     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALVE = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } state_t;

    // Increment that sticks at the all-ones value.
    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] x);
        return (x == {HW{1'b1}}) ? x : x + HW'(1);
    endfunction

endpackage

// File: rtl/hl_prescaler.sv
// Cycle prescaler: counts while enabled, flags the last cycle of each period.
module hl_prescaler
    import halflife_pkg::*;
#(
    parameter int unsigned PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          tc
);

    logic [PW-1:0] cnt;

    // Count register; clear wins over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PW'(1);
        end
    end

    // Terminal count: this enabled cycle is the last one of the period.
    assign tc = en && (cnt == period - PW'(1));

endmodule

// File: rtl/halflife_ctrl.sv
// Half-life decay controller: loads a counter, then halves it once per period
// until it reaches zero. Outputs are registered from the next state.
module halflife_ctrl
    import halflife_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  init_val,
    input  logic [PW-1:0] period,
    input  logic [N-1:0]  cnt_val,
    output logic          cnt_load,
    output logic [N-1:0]  cnt_in,
    output logic          cnt_clr,
    output logic          cnt_up,
    output logic          cnt_down,
    output logic          busy,
    output logic          done,
    output logic [HW-1:0] halvings
);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] period_q;
    logic          tc;
    logic          accept_c;
    logic          load_nx;
    logic [N-1:0]  cnt_in_nx;
    logic          clr_nx;
    logic          busy_nx;
    logic          done_nx;

    // The controller only loads or clears the counter.
    assign cnt_up   = 1'b0;
    assign cnt_down = 1'b0;

    // Prescaler runs only in WAIT and restarts from zero on every WAIT entry.
    hl_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_WAIT),
        .en     (state == ST_WAIT),
        .period (period_q),
        .tc     (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the output values that next state will present.
    always_comb begin
        state_nx  = state;
        accept_c  = 1'b0;
        load_nx   = 1'b0;
        cnt_in_nx = '0;
        clr_nx    = 1'b0;
        busy_nx   = 1'b1;
        done_nx   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_LOAD;
                    accept_c = 1'b1;
                end
            end
            ST_LOAD:  state_nx = ST_WAIT;
            ST_WAIT: begin
                if (cnt_val == '0) begin
                    state_nx = ST_DONE;
                end else if (tc) begin
                    state_nx = ST_HALVE;
                end
            end
            ST_HALVE: state_nx = ST_WAIT;
            ST_DONE:  state_nx = ST_IDLE;
            ST_CLEAR: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase

        if (abort && (state inside {ST_LOAD, ST_WAIT, ST_HALVE, ST_DONE})) begin
            state_nx = ST_CLEAR;
        end

        case (state_nx)
            ST_IDLE:  busy_nx = 1'b0;
            ST_LOAD: begin
                // LOAD is only entered from IDLE, so init_val is the value being latched.
                load_nx   = 1'b1;
                cnt_in_nx = init_val;
            end
            ST_HALVE: begin
                // The counter does not change between WAIT and HALVE.
                load_nx   = 1'b1;
                cnt_in_nx = cnt_val >> 1;
            end
            ST_DONE:  done_nx = 1'b1;
            ST_CLEAR: clr_nx  = 1'b1;
            default:  busy_nx = 1'b1;
        endcase
    end

    // Registered outputs, latched period and halving count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_load <= 1'b0;
            cnt_in   <= '0;
            cnt_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            period_q <= '0;
            halvings <= '0;
        end else begin
            cnt_load <= load_nx;
            cnt_in   <= cnt_in_nx;
            cnt_clr  <= clr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            if (accept_c) begin
                period_q <= (period == '0) ? PW'(1) : period;
                halvings <= '0;
            end else if (state == ST_HALVE) begin
                halvings <= sat_inc(halvings);
            end
        end
    end

endmodule

// File: tb/tb_halflife_ctrl.sv
// Bench for halflife_ctrl wired back to back with a half-life counter.
module tb_halflife_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 8;

    typedef struct packed {
        logic       load;
        logic [3:0] cin;
        logic       clr;
        logic       busy;
        logic       done;
        logic [3:0] halv;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [N-1:0]  init_val;
    logic [PW-1:0] period;
    logic [N-1:0]  cnt_val;
    logic          cnt_load;
    logic [N-1:0]  cnt_in;
    logic          cnt_clr;
    logic          cnt_up;
    logic          cnt_down;
    logic          busy;
    logic          done;
    logic [3:0]    halvings;

    exp_t exp_q[$];
    int   idle_h = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   run_base = 0;
    int   ld_cyc[$];
    int   ld_val[$];
    int   done_at = -1;
    int   clr_n   = 0;
    int   clr_at  = -1;

    halflife_ctrl #(.N(N), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .init_val (init_val),
        .period   (period),
        .cnt_val  (cnt_val),
        .cnt_load (cnt_load),
        .cnt_in   (cnt_in),
        .cnt_clr  (cnt_clr),
        .cnt_up   (cnt_up),
        .cnt_down (cnt_down),
        .busy     (busy),
        .done     (done),
        .halvings (halvings)
    );

    // Half-life counter: one-cycle load/clear/count latency.
    always @(posedge clk or negedge rst) begin
        if (!rst)          cnt_val <= '0;
        else if (cnt_clr)  cnt_val <= '0;
        else if (cnt_load) cnt_val <= cnt_in;
        else if (cnt_up)   cnt_val <= cnt_val + 4'd1;
        else if (cnt_down) cnt_val <= cnt_val - 4'd1;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic l, input int ci, input logic c,
                                input logic b, input logic d, input int h);
        exp_t r;
        r.load = l;
        r.cin  = 4'(ci);
        r.clr  = c;
        r.busy = b;
        r.done = d;
        r.halv = 4'(h);
        return r;
    endfunction

    // Expected per-cycle trace of one run, starting with the cycle start is held.
    task automatic build(input int iv, input int pv, input int abort_at);
        exp_t q[$];
        int   p;
        int   v;
        int   h;
        p = (pv == 0) ? 1 : pv;
        v = iv;
        h = 0;
        q.push_back(mk(0, 0, 0, 0, 0, idle_h));
        q.push_back(mk(1, iv, 0, 1, 0, 0));
        for (int k = 0; k < 20; k++) begin
            if (v == 0) begin
                q.push_back(mk(0, 0, 0, 1, 0, h));
                q.push_back(mk(0, 0, 0, 1, 1, h));
                break;
            end
            for (int w = 0; w < p; w++) q.push_back(mk(0, 0, 0, 1, 0, h));
            v = v / 2;
            q.push_back(mk(1, v, 0, 1, 0, h));
            h = (h == 15) ? 15 : h + 1;
        end
        if (abort_at >= 0) begin
            h = int'(q[abort_at].halv);
            while (q.size() > abort_at + 1) void'(q.pop_back());
            q.push_back(mk(0, 0, 1, 1, 0, h));
        end
        foreach (q[i]) exp_q.push_back(q[i]);
        idle_h = h;
    endtask

    // Cycle-by-cycle comparison against the model, plus event logging.
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        a = mk(cnt_load, int'(cnt_in), cnt_clr, busy, done, int'(halvings));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk(0, 0, 0, 0, 0, idle_h);
        n_cmp++;
        if (a !== e || cnt_up !== 1'b0 || cnt_down !== 1'b0) begin
            n_bad++;
            $display("FAIL outputs t=%0t: got load=%0b in=%0d clr=%0b busy=%0b done=%0b halv=%0d up=%0b dn=%0b, want load=%0b in=%0d clr=%0b busy=%0b done=%0b halv=%0d up=0 dn=0",
                     $time, a.load, a.cin, a.clr, a.busy, a.done, a.halv, cnt_up, cnt_down,
                     e.load, e.cin, e.clr, e.busy, e.done, e.halv);
        end
        if (cnt_load === 1'b1) begin
            ld_cyc.push_back(cyc - run_base);
            ld_val.push_back(int'(cnt_in));
        end
        if (done === 1'b1) done_at = cyc - run_base;
        if (cnt_clr === 1'b1) begin
            clr_n++;
            clr_at = cyc - run_base;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic chk_loads(input string nm, input int ec[5], input int ev[5]);
        chk({nm, "_n"}, ld_cyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk({nm, "_cyc"}, (i < ld_cyc.size()) ? ld_cyc[i] : -1, ec[i]);
            chk({nm, "_val"}, (i < ld_val.size()) ? ld_val[i] : -1, ev[i]);
        end
    endtask

    // Called one tick after a rising edge with an empty model queue.
    task automatic launch(input int iv, input int pv, input int abort_at);
        ld_cyc.delete();
        ld_val.delete();
        done_at  = -1;
        clr_n    = 0;
        clr_at   = -1;
        run_base = cyc;
        build(iv, pv, abort_at);
        init_val = 4'(iv);
        period   = 8'(pv);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: model queue depth %0d, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int c035[5];
        int v035[5];
        int c037[5];
        int v037[5];
        c035 = '{1, 5, 9, 13, 17};
        v035 = '{12, 6, 3, 1, 0};
        c037 = '{1, 3, 5, 7, 9};
        v037 = '{15, 7, 3, 1, 0};

        rst = 1'b0; start = 1'b0; abort = 1'b0; init_val = '0; period = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_halvings", int'(halvings), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Nominal decay 12 -> 0 with period 3.
        launch(12, 3, -1);
        wait_idle();
        chk_loads("r035", c035, v035);
        chk("r035_done", done_at, 19);
        chk("r035_halvings", int'(halvings), 4);

        // Zero initial value finishes without halving.
        launch(0, 5, -1);
        wait_idle();
        chk("r036_done", done_at, 3);
        chk("r036_loads", ld_cyc.size(), 1);
        chk("r036_halvings", int'(halvings), 0);

        // Period 0 behaves as period 1.
        launch(15, 0, -1);
        wait_idle();
        chk_loads("r037", c037, v037);
        chk("r037_done", done_at, 11);

        // Abort in the second WAIT cycle.
        launch(12, 3, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle();
        chk("r038_clr_n", clr_n, 1);
        chk("r038_clr_at", clr_at, 4);
        chk("r038_done", done_at, -1);
        launch(6, 2, -1);
        wait_idle();
        chk("r038_restart_done", done_at, 12);
        chk("r038_restart_halv", int'(halvings), 3);

        // Start re-asserted while busy is ignored.
        launch(12, 3, -1);
        start = 1'b1; init_val = 4'd9; period = 8'd1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk_loads("r039", c035, v035);
        chk("r039_done", done_at, 19);

        // Asynchronous reset during the second HALVE (cycle 9).
        launch(12, 3, -1);
        repeat (8) @(posedge clk);
        #1;
        chk("r040_halve_load", int'(cnt_load), 1);
        chk("r040_halve_in", int'(cnt_in), 3);
        chk("r040_halve_halv", int'(halvings), 1);
        #1;
        rst = 1'b0;
        exp_q.delete();
        idle_h = 0;
        #1;
        chk("r040_async", int'({cnt_load, cnt_in, cnt_clr, busy, done, halvings}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("r040_post_halv", int'(halvings), 0);
        chk("r040_post_done", done_at, -1);
        chk("r040_post_clr", clr_n, 0);

        // Recovery run after reset.
        launch(5, 2, -1);
        wait_idle();
        chk("recover_done", done_at, 12);
        chk("recover_halv", int'(halvings), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
